// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath.
// Contents:
//   - layer-size constants for the whole network
//   - state encoding of the layer-1 sequencer FSM
//   - relu helper at the network's native data width
// No ports (package).
package nn_pkg;

  localparam int NN_INPUT_SIZE   = 784;
  localparam int NN_HIDDEN1_SIZE = 64;
  localparam int NN_HIDDEN2_SIZE = 32;
  localparam int NN_OUTPUT_SIZE  = 10;
  localparam int NN_DATA_W       = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } seq_state_e;

  // Negative and zero map to zero.
  function automatic logic signed [NN_DATA_W-1:0] relu(input logic signed [NN_DATA_W-1:0] x);
    return x[NN_DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/nn_layer1_sequencer_if.sv
// Bus bundle between the layer-1 sequencer and its surroundings
// (pass control, weights BRAM, bias table, hidden1 register file).
// Signals:
//   start/features     pass request and latched binary feature vector
//   busy/done          pass in progress / one-cycle completion pulse
//   w_addr/w_data      weights BRAM read port, data valid one cycle after address
//   b_addr/b_data      bias table, combinational read
//   h_we/h_addr/h_data hidden1 write port
// Handshake: start is a level sampled only while the sequencer is idle; each
// accepted start runs exactly one pass, busy covers the pass, done pulses once
// at its end. There is no backpressure and requests are not queued.
// Modports: slave = sequencer side, master = system side.
interface nn_layer1_sequencer_if
  import nn_pkg::*;
#(
  parameter int INPUT_SIZE  = NN_INPUT_SIZE,
  parameter int HIDDEN_SIZE = NN_HIDDEN1_SIZE,
  parameter int DATA_W      = NN_DATA_W,
  parameter int ADDR_W      = 16
);
  localparam int HW = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;

  logic                     start;
  logic [INPUT_SIZE-1:0]    features;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic [HW-1:0]            b_addr;
  logic signed [DATA_W-1:0] b_data;
  logic                     h_we;
  logic [HW-1:0]            h_addr;
  logic signed [DATA_W-1:0] h_data;

  modport slave (
    input  start, features, w_data, b_data,
    output busy, done, w_addr, b_addr, h_we, h_addr, h_data
  );

  modport master (
    output start, features, w_data, b_data,
    input  busy, done, w_addr, b_addr, h_we, h_addr, h_data
  );

endinterface

// File: rtl/nn_mac_acc.sv
// Signed accumulator for one neuron: load with bias, add one weight per
// enabled cycle.
// Configuration macro NN_L1_SAT_EN: when defined every addition saturates to
// the signed DATA_W range; otherwise it wraps in two's complement.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load_i      load load_val_i (takes priority over en_i)
//   load_val_i  bias value
//   en_i        add add_val_i this cycle
//   add_val_i   weight value
//   acc_o       current accumulator value
module nn_mac_acc #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] load_val_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] add_val_i,
  output logic signed [DATA_W-1:0] acc_o
);
  logic signed [DATA_W-1:0] acc_q, acc_d, sum;

`ifdef NN_L1_SAT_EN
  // One guard bit: the top two bits disagree exactly when the sum overflowed.
  logic signed [DATA_W:0] sum_w;
  always_comb begin
    sum_w = {acc_q[DATA_W-1], acc_q} + {add_val_i[DATA_W-1], add_val_i};
    if (sum_w[DATA_W] != sum_w[DATA_W-1]) begin
      sum = sum_w[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sum = sum_w[DATA_W-1:0];
    end
  end
`else
  assign sum = acc_q + add_val_i;
`endif

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = load_val_i;
    end else if (en_i) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/nn_layer1_sequencer.sv
// Layer-1 sequencer: computes every hidden neuron serially against the
// single-port weights BRAM, one weight word per cycle, then ReLU and write to
// hidden1. Per neuron: INPUT_SIZE fetch cycles, one drain cycle for the last
// BRAM word, one write cycle. Weights of zero features are still fetched so
// the pass length is fixed.
// Configuration macro NN_L1_SAT_EN (in nn_mac_acc): saturating accumulation.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       nn_layer1_sequencer_if.slave (start/features, busy/done,
//             weights BRAM, bias table, hidden1 write port)
//   state_o   current FSM state (debug)
module nn_layer1_sequencer
  import nn_pkg::*;
#(
  parameter int INPUT_SIZE  = NN_INPUT_SIZE,
  parameter int HIDDEN_SIZE = NN_HIDDEN1_SIZE,
  parameter int DATA_W      = NN_DATA_W,
  parameter int ADDR_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nn_layer1_sequencer_if.slave bus,
  output seq_state_e           state_o
);
  localparam int JW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
  localparam int NW = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
  localparam logic [JW-1:0]     J_LAST    = JW'(INPUT_SIZE - 1);
  localparam logic [NW-1:0]     N_LAST    = NW'(HIDDEN_SIZE - 1);
  localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(INPUT_SIZE);

  seq_state_e               state_q, state_d;
  logic [NW-1:0]            n_q, n_d;
  logic [JW-1:0]            j_q, j_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [INPUT_SIZE-1:0]    feat_q;
  logic                     valid_q, fbit_q;
  logic                     busy_q, done_q, h_we_q;
  logic [NW-1:0]            h_addr_q;
  logic signed [DATA_W-1:0] h_data_q;
  logic                     acc_load;
  logic signed [DATA_W-1:0] acc;
  logic                     accept;

  assign accept = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    j_d      = j_q;
    base_d   = base_q;
    acc_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          n_d     = '0;
          j_d     = '0;
          base_d  = '0;
        end
      end
      ACCUM: begin
        // The bias goes in on the first fetch cycle of each neuron: the
        // pipeline is empty then and b_addr already points at the neuron.
        acc_load = (j_q == '0);
        if (j_q == J_LAST) begin
          state_d = DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (n_q == N_LAST) begin
          state_d = FIN;
        end else begin
          state_d = ACCUM;
          n_d     = n_q + 1'b1;
          j_d     = '0;
          base_d  = base_q + BASE_STEP;
        end
      end
      FIN: begin
        state_d = IDLE;
        n_d     = '0;
        j_d     = '0;
        base_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      j_q      <= '0;
      base_q   <= '0;
      valid_q  <= 1'b0;
      fbit_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      h_we_q   <= 1'b0;
      h_addr_q <= '0;
      h_data_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      j_q     <= j_d;
      base_q  <= base_d;
      // Delay line matching the one-cycle BRAM read latency.
      valid_q <= (state_q == ACCUM);
      fbit_q  <= feat_q[j_q];
      h_we_q  <= (state_q == WRITE);
      done_q  <= (state_q == FIN);
      if (state_q == WRITE) begin
        h_addr_q <= n_q;
        h_data_q <= acc[DATA_W-1] ? '0 : acc;
      end
      if (accept) begin
        busy_q <= 1'b1;
      end else if (state_q == FIN) begin
        busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      feat_q <= bus.features;
    end
  end

  nn_mac_acc #(
    .DATA_W(DATA_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (acc_load),
    .load_val_i(bus.b_data),
    .en_i      (valid_q & fbit_q),
    .add_val_i (bus.w_data),
    .acc_o     (acc)
  );

  assign bus.w_addr = base_q + ADDR_W'(j_q);
  assign bus.b_addr = n_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.h_we   = h_we_q;
  assign bus.h_addr = h_addr_q;
  assign bus.h_data = h_data_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_nn_layer1_sequencer.sv
// Bench for nn_layer1_sequencer: a small instance (4 features, 2 neurons) for
// directed and randomized passes, plus a full-size instance for one pass.
module tb_nn_layer1_sequencer;
  import nn_pkg::*;

  localparam int SI = 4;
  localparam int SH = 2;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DI = NN_INPUT_SIZE;
  localparam int DH = NN_HIDDEN1_SIZE;
  localparam int S_LAT = SH * (SI + 2) + 1;
  localparam int D_LAT = DH * (DI + 2) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  nn_layer1_sequencer_if #(.INPUT_SIZE(SI), .HIDDEN_SIZE(SH), .DATA_W(DW), .ADDR_W(AW)) bus_s ();
  nn_layer1_sequencer_if #(.INPUT_SIZE(DI), .HIDDEN_SIZE(DH), .DATA_W(DW), .ADDR_W(AW)) bus_d ();
  seq_state_e dbg_s, dbg_d;

  nn_layer1_sequencer #(.INPUT_SIZE(SI), .HIDDEN_SIZE(SH), .DATA_W(DW), .ADDR_W(AW)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .state_o(dbg_s));
  nn_layer1_sequencer #(.INPUT_SIZE(DI), .HIDDEN_SIZE(DH), .DATA_W(DW), .ADDR_W(AW)) dut_d (
    .clk(clk), .rst(rst), .bus(bus_d), .state_o(dbg_d));

  // ---------------- memory models ----------------
  logic signed [DW-1:0] wmem_s [SI*SH];
  logic signed [DW-1:0] bmem_s [SH];
  logic signed [DW-1:0] wmem_d [DI*DH];
  logic signed [DW-1:0] bmem_d [DH];

  always @(posedge clk) bus_s.w_data <= wmem_s[bus_s.w_addr[2:0]];
  always @(posedge clk) bus_d.w_data <= wmem_d[bus_d.w_addr];
  assign bus_s.b_data = bmem_s[bus_s.b_addr];
  assign bus_d.b_data = bmem_d[bus_d.b_addr];

  // ---------------- output collectors ----------------
  int              got_s_addr[$];
  logic [DW-1:0]   got_s_data[$];
  int              got_d_addr[$];
  logic [DW-1:0]   got_d_data[$];
  int              done_cnt_s = 0;
  int              done_cnt_d = 0;
  logic [DW-1:0]   exp_q[$];
  logic [SI-1:0]   feat_s;

  always @(negedge clk) begin
    if (bus_s.h_we === 1'b1) begin
      got_s_addr.push_back(int'(bus_s.h_addr));
      got_s_data.push_back(bus_s.h_data);
    end
    if (bus_s.done === 1'b1) done_cnt_s++;
    if (bus_d.h_we === 1'b1) begin
      got_d_addr.push_back(int'(bus_d.h_addr));
      got_d_data.push_back(bus_d.h_data);
    end
    if (bus_d.done === 1'b1) done_cnt_d++;
  end

  // ---------------- reference model ----------------
  // Neuron value = relu(bias + sum of weights whose feature is set), in plain
  // integer arithmetic; wraps to DW bits at the end or clamps every step.
  function automatic logic [DW-1:0] model_s(input int n);
    int s;
    logic signed [DW-1:0] t;
    s = int'(bmem_s[n]);
    for (int j = 0; j < SI; j++) begin
      if (feat_s[j]) begin
        s = s + int'(wmem_s[n*SI + j]);
`ifdef NN_L1_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
      end
    end
    t = s[DW-1:0];
    return (t <= 0) ? '0 : t;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_s();
    got_s_addr.delete();
    got_s_data.delete();
    done_cnt_s = 0;
  endtask

  task automatic set_directed();
    wmem_s = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd5, 16'sd1, 16'sd1, 16'sd1};
    bmem_s = '{16'sd10, 16'sd0};
  endtask

  // One-cycle start pulse; lat = cycles from accept edge to done, -1 on timeout.
  task automatic run_pass_s(input logic [SI-1:0] f, output int lat);
    clear_s();
    feat_s = f;
    @(negedge clk);
    bus_s.features = f;
    bus_s.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (bus_s.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus_s.start = 1'b0; bus_s.features = '0;
    bus_d.start = 1'b0; bus_d.features = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus_s.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus_s.busy); else n_pass++;
    n_checks++; if (bus_s.done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", bus_s.done); else n_pass++;
    n_checks++; if (bus_s.h_we !== 1'b0) $display("FAIL reset_h_we: got %0b expected 0", bus_s.h_we); else n_pass++;
    n_checks++; if (bus_s.h_data !== '0) $display("FAIL reset_h_data: got %0d expected 0", bus_s.h_data); else n_pass++;
    n_checks++; if (bus_s.w_addr !== '0) $display("FAIL reset_w_addr: got %0d expected 0", bus_s.w_addr); else n_pass++;
    n_checks++; if (dbg_s !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_s, IDLE); else n_pass++;
    n_checks++; if (bus_d.busy !== 1'b0) $display("FAIL reset_busy_full: got %0b expected 0", bus_d.busy); else n_pass++;
  endtask

  task automatic test_directed();
    int lat;
    set_directed();
    exp_q.delete();
    exp_q.push_back(16'd14);
    exp_q.push_back(16'd0);
    run_pass_s(4'b0101, lat);
    n_checks++; if (lat != S_LAT) $display("FAIL directed_latency: got %0d expected %0d", lat, S_LAT); else n_pass++;
    n_checks++; if (done_cnt_s != 1) $display("FAIL directed_done_cnt: got %0d expected 1", done_cnt_s); else n_pass++;
    n_checks++; if (got_s_data.size() != SH) $display("FAIL directed_writes: got %0d expected %0d", got_s_data.size(), SH); else n_pass++;
    for (int k = 0; k < SH; k++) begin
      logic [DW-1:0] g;
      int ga;
      g  = (k < got_s_data.size()) ? got_s_data[k] : 'x;
      ga = (k < got_s_addr.size()) ? got_s_addr[k] : -1;
      n_checks++; if (g !== exp_q[k]) $display("FAIL directed_h%0d: got %0d expected %0d", k, g, exp_q[k]); else n_pass++;
      n_checks++; if (ga != k) $display("FAIL directed_addr%0d: got %0d expected %0d", k, ga, k); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat;
    for (int it = 0; it < 12; it++) begin
      logic [SI-1:0] f;
      for (int a = 0; a < SI*SH; a++) wmem_s[a] = DW'($urandom);
      for (int n = 0; n < SH; n++) bmem_s[n] = DW'($urandom);
      f = SI'($urandom_range(0, (1 << SI) - 1));
      feat_s = f;
      exp_q.delete();
      for (int n = 0; n < SH; n++) exp_q.push_back(model_s(n));
      run_pass_s(f, lat);
      n_checks++; if (lat != S_LAT) $display("FAIL random%0d_latency: got %0d expected %0d", it, lat, S_LAT); else n_pass++;
      for (int k = 0; k < SH; k++) begin
        logic [DW-1:0] g;
        g = (k < got_s_data.size()) ? got_s_data[k] : 'x;
        n_checks++; if (g !== exp_q[k]) $display("FAIL random%0d_h%0d: got %0d expected %0d", it, k, g, exp_q[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [DW-1:0] e;
`ifdef NN_L1_SAT_EN
    e = 16'h7FFF;
`else
    e = 16'h0000;
`endif
    for (int a = 0; a < SI*SH; a++) wmem_s[a] = 16'sh7000;
    bmem_s = '{16'sd0, 16'sd0};
    run_pass_s(4'b1111, lat);
    for (int k = 0; k < SH; k++) begin
      logic [DW-1:0] g;
      g = (k < got_s_data.size()) ? got_s_data[k] : 'x;
      n_checks++; if (g !== e) $display("FAIL overflow_h%0d: got %0h expected %0h", k, g, e); else n_pass++;
    end
  endtask

  task automatic test_bram_latency();
    int lat;
    for (int a = 0; a < SI*SH; a++) wmem_s[a] = DW'(a);
    for (int n = 0; n < SH; n++) bmem_s[n] = DW'($urandom_range(0, 100));
    exp_q.delete();
    for (int n = 0; n < SH; n++) exp_q.push_back(DW'(n*SI + SI - 1 + int'(bmem_s[n])));
    run_pass_s(4'b1000, lat);
    for (int k = 0; k < SH; k++) begin
      logic [DW-1:0] g;
      g = (k < got_s_data.size()) ? got_s_data[k] : 'x;
      n_checks++; if (g !== exp_q[k]) $display("FAIL bram_latency_h%0d: got %0d expected %0d", k, g, exp_q[k]); else n_pass++;
    end
  endtask

  // start stays high through the whole pass including the FIN cycle.
  task automatic test_start_hold();
    set_directed();
    clear_s();
    @(negedge clk);
    bus_s.features = 4'b0101;
    bus_s.start = 1'b1;
    @(posedge clk);
    repeat (S_LAT) @(posedge clk);
    @(negedge clk);
    bus_s.start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (done_cnt_s != 1) $display("FAIL hold_done_cnt: got %0d expected 1", done_cnt_s); else n_pass++;
    n_checks++; if (got_s_data.size() != SH) $display("FAIL hold_writes: got %0d expected %0d", got_s_data.size(), SH); else n_pass++;
    n_checks++; if (bus_s.busy !== 1'b0) $display("FAIL hold_busy_after: got %0b expected 0", bus_s.busy); else n_pass++;
  endtask

  // A start raised in the done cycle is accepted on the next edge.
  task automatic test_back_to_back();
    int lat;
    set_directed();
    run_pass_s(4'b0101, lat);
    clear_s();
    bus_s.start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus_s.busy !== 1'b1) $display("FAIL b2b_busy: got %0b expected 1", bus_s.busy); else n_pass++;
    @(negedge clk);
    bus_s.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (bus_s.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    @(negedge clk); #1;
    n_checks++; if (lat != S_LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, S_LAT); else n_pass++;
    n_checks++; if (got_s_data.size() != SH) $display("FAIL b2b_writes: got %0d expected %0d", got_s_data.size(), SH); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    set_directed();
    clear_s();
    @(negedge clk);
    bus_s.features = 4'b0101;
    bus_s.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus_s.h_we !== 1'b0) $display("FAIL rstmid_h_we: got %0b expected 0", bus_s.h_we); else n_pass++;
    n_checks++; if (bus_s.busy !== 1'b0) $display("FAIL rstmid_busy: got %0b expected 0", bus_s.busy); else n_pass++;
    n_checks++; if (dbg_s !== IDLE) $display("FAIL rstmid_state: got %0d expected %0d", dbg_s, IDLE); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (got_s_data.size() != 1) $display("FAIL rstmid_writes: got %0d expected 1", got_s_data.size()); else n_pass++;
    n_checks++; if (done_cnt_s != 0) $display("FAIL rstmid_done: got %0d expected 0", done_cnt_s); else n_pass++;
    run_pass_s(4'b0101, lat);
    n_checks++; if (lat != S_LAT) $display("FAIL rstmid_latency: got %0d expected %0d", lat, S_LAT); else n_pass++;
    n_checks++; if (got_s_data.size() != SH || got_s_data[0] !== 16'd14 || got_s_data[1] !== 16'd0)
      $display("FAIL rstmid_results: got %0d writes expected h0=14 h1=0", got_s_data.size());
    else n_pass++;
  endtask

  task automatic test_defaults();
    int lat;
    int busy_low;
    for (int a = 0; a < DI*DH; a++) wmem_d[a] = DW'($urandom);
    for (int n = 0; n < DH; n++) bmem_d[n] = DW'(n);
    got_d_addr.delete();
    got_d_data.delete();
    done_cnt_d = 0;
    @(negedge clk);
    bus_d.features = '0;
    bus_d.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_d.start = 1'b0;
    lat = -1;
    busy_low = 0;
    for (int c = 1; c <= D_LAT + 100; c++) begin
      @(posedge clk); #1;
      if (bus_d.done === 1'b1) begin
        lat = c;
        break;
      end
      if (bus_d.busy !== 1'b1) busy_low++;
    end
    @(negedge clk); #1;
    n_checks++; if (lat != D_LAT) $display("FAIL full_latency: got %0d expected %0d", lat, D_LAT); else n_pass++;
    n_checks++; if (busy_low != 0) $display("FAIL full_busy: got %0d low cycles expected 0", busy_low); else n_pass++;
    n_checks++; if (got_d_data.size() != DH) $display("FAIL full_writes: got %0d expected %0d", got_d_data.size(), DH); else n_pass++;
    for (int k = 0; k < DH; k++) begin
      logic [DW-1:0] g;
      int ga;
      g  = (k < got_d_data.size()) ? got_d_data[k] : 'x;
      ga = (k < got_d_addr.size()) ? got_d_addr[k] : -1;
      n_checks++; if (g !== DW'(k) || ga != k) $display("FAIL full_h%0d: got addr %0d data %0d expected %0d", k, ga, g, k); else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overflow();
    test_bram_latency();
    test_start_hold();
    test_back_to_back();
    test_reset_mid();
    test_defaults();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
